// File: rtl/fifo_sync_pkt.sv
// Single-clock FIFO with packet commit/drop: readers only see committed words.
// Optional saturating packet statistics are built when FIFO_SYNC_PKT_STATS_EN is defined.
module fifo_sync_pkt #(
    parameter int pDATA_WIDTH  = 8,
    parameter int pDEPTH       = 64,
    parameter int pFALLTHROUGH = 0,
    localparam int pADDR_WIDTH = $clog2(pDEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wen,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wcommit,
    input  logic                   wdrop,
    output logic                   full,
    input  logic [pADDR_WIDTH:0]   full_threshold_value,
    output logic                   full_threshold,
    output logic                   overflow,
    output logic                   drop_event,
    input  logic                   ren,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   empty,
    output logic                   underflow,
    output logic [pADDR_WIDTH:0]   rcount,
    output logic [pADDR_WIDTH:0]   wcount,
    output logic [15:0]            pkt_committed_count,
    output logic [15:0]            pkt_dropped_count
);

    localparam logic [pADDR_WIDTH:0] DEPTH_W = (pADDR_WIDTH+1)'(pDEPTH);

    logic [pDATA_WIDTH-1:0] mem [pDEPTH];

    logic [pADDR_WIDTH:0] wptr_spec_q, wptr_spec_d;
    logic [pADDR_WIDTH:0] wptr_commit_q, wptr_commit_d;
    logic [pADDR_WIDTH:0] rptr_q, rptr_d;
    logic [pADDR_WIDTH:0] wptr_spec_post;
    logic                 pkt_err_q, pkt_err_d;
    logic                 overflow_q, underflow_q, drop_event_q;

    logic wr_ok, rd_ok, poison_now, drop_now, commit_ok;

    // Occupancy: the speculative pointer counts open words against capacity.
    assign wcount         = wptr_spec_q - rptr_q;
    assign rcount         = wptr_commit_q - rptr_q;
    assign full           = (wcount == DEPTH_W);
    assign empty          = (rptr_q == wptr_commit_q);
    assign full_threshold = (wcount >= full_threshold_value);

    assign wr_ok          = wen && !full;
    assign rd_ok          = ren && !empty;
    assign poison_now     = wen && full;
    assign wptr_spec_post = wptr_spec_q + (pADDR_WIDTH+1)'(wr_ok);

    // A commit on a poisoned packet (sticky or same-cycle) turns into a drop.
    assign drop_now  = wdrop || (wcommit && (pkt_err_q || poison_now));
    assign commit_ok = wcommit && !drop_now;

    always_comb begin
        wptr_spec_d   = drop_now ? wptr_commit_q : wptr_spec_post;
        wptr_commit_d = commit_ok ? wptr_spec_post : wptr_commit_q;
        rptr_d        = rptr_q + (pADDR_WIDTH+1)'(rd_ok);
        pkt_err_d     = (wcommit || wdrop) ? 1'b0 : (pkt_err_q || poison_now);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_spec_q   <= '0;
            wptr_commit_q <= '0;
            rptr_q        <= '0;
            pkt_err_q     <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            drop_event_q  <= 1'b0;
        end else begin
            wptr_spec_q   <= wptr_spec_d;
            wptr_commit_q <= wptr_commit_d;
            rptr_q        <= rptr_d;
            pkt_err_q     <= pkt_err_d;
            overflow_q    <= poison_now;
            underflow_q   <= ren && empty;
            drop_event_q  <= drop_now;
        end
    end

    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign drop_event = drop_event_q;

    // Storage has no reset so it can map onto RAM; slots past the commit pointer are don't-care.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr_spec_q[pADDR_WIDTH-1:0]] <= wdata;
    end

    generate
        if (pFALLTHROUGH != 0) begin : g_fwft
            assign rdata = mem[rptr_q[pADDR_WIDTH-1:0]];
        end else begin : g_reg
            logic [pDATA_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rdata_q <= '0;
                else if (rd_ok)
                    rdata_q <= mem[rptr_q[pADDR_WIDTH-1:0]];
            end
            assign rdata = rdata_q;
        end
    endgenerate

`ifdef FIFO_SYNC_PKT_STATS_EN
    logic [15:0] commit_cnt_q, drop_cnt_q;

    // Drop counter advances on the same edge that raises drop_event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (commit_ok && commit_cnt_q != 16'hFFFF)
                commit_cnt_q <= commit_cnt_q + 16'd1;
            if (drop_now && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign pkt_committed_count = commit_cnt_q;
    assign pkt_dropped_count   = drop_cnt_q;
`else
    assign pkt_committed_count = 16'h0000;
    assign pkt_dropped_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_sync_pkt.sv
// Directed bench: a registered-read and a fall-through FIFO (depth 8) share one stimulus stream.
module tb_fifo_sync_pkt;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wen = 1'b0, wcommit = 1'b0, wdrop = 1'b0, ren = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [AW:0] thr = '0;

    logic full_a, ft_a, ovf_a, drp_a, emp_a, unf_a;
    logic full_b, ft_b, ovf_b, drp_b, emp_b, unf_b;
    logic [DW-1:0] rd_a, rd_b;
    logic [AW:0] rc_a, wc_a, rc_b, wc_b;
    logic [15:0] pc_a, pd_a, pc_b, pd_b;

    int total = 0;
    int bad = 0;
    int n_commit_exp = 0;
    int n_drop_exp = 0;

    always #5 clk = ~clk;

    fifo_sync_pkt #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pFALLTHROUGH(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata), .wcommit(wcommit), .wdrop(wdrop),
        .full(full_a), .full_threshold_value(thr), .full_threshold(ft_a), .overflow(ovf_a),
        .drop_event(drp_a), .ren(ren), .rdata(rd_a), .empty(emp_a), .underflow(unf_a),
        .rcount(rc_a), .wcount(wc_a), .pkt_committed_count(pc_a), .pkt_dropped_count(pd_a));

    fifo_sync_pkt #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pFALLTHROUGH(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata), .wcommit(wcommit), .wdrop(wdrop),
        .full(full_b), .full_threshold_value(thr), .full_threshold(ft_b), .overflow(ovf_b),
        .drop_event(drp_b), .ren(ren), .rdata(rd_b), .empty(emp_b), .underflow(unf_b),
        .rcount(rc_b), .wcount(wc_b), .pkt_committed_count(pc_b), .pkt_dropped_count(pd_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Both instances must agree on every status output.
    task automatic status(input string tag, input logic e, input logic f,
                          input logic [AW:0] rc, input logic [AW:0] wc);
        chk({tag, ".empty"}, {emp_a, emp_b}, {e, e});
        chk({tag, ".full"},  {full_a, full_b}, {f, f});
        chk({tag, ".rcount"}, {rc_a, rc_b}, {rc, rc});
        chk({tag, ".wcount"}, {wc_a, wc_b}, {wc, wc});
    endtask

    task automatic pulses(input string tag, input logic ov, input logic un, input logic dr);
        chk({tag, ".pulses"}, {ovf_a, ovf_b, unf_a, unf_b, drp_a, drp_b},
            {ov, ov, un, un, dr, dr});
    endtask

    task automatic put(input logic [DW-1:0] d, input logic commit);
        wen = 1'b1; wdata = d; wcommit = commit;
        cyc();
        wen = 1'b0; wcommit = 1'b0;
        if (commit) n_commit_exp++;
    endtask

    // FWFT data is checked before the pop, registered data one cycle after it.
    task automatic pop(input string tag, input logic [DW-1:0] d);
        chk({tag, ".fwft"}, {emp_b, rd_b}, {1'b0, d});
        ren = 1'b1;
        cyc();
        ren = 1'b0;
        chk({tag, ".reg"}, {rd_a, unf_a, unf_b}, {d, 1'b0, 1'b0});
    endtask

    task automatic stats(input string tag);
`ifdef FIFO_SYNC_PKT_STATS_EN
        chk({tag, ".stats"}, {pc_a, pd_a, pc_b, pd_b},
            {16'(n_commit_exp), 16'(n_drop_exp), 16'(n_commit_exp), 16'(n_drop_exp)});
`else
        chk({tag, ".stats"}, {pc_a, pd_a, pc_b, pd_b}, 64'd0);
`endif
    endtask

    initial begin
        // Reset state, threshold 0 means full_threshold is high at empty.
        #12;
        status("rst", 1'b1, 1'b0, 4'd0, 4'd0);
        chk("rst.thr0", {ft_a, ft_b}, 2'b11);
        chk("rst.rdata", rd_a, 8'h00);
        pulses("rst", 1'b0, 1'b0, 1'b0);
        thr = 4'd5;
        #1;
        chk("rst.thr5", {ft_a, ft_b}, 2'b00);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Five words, commit with the fifth; open words stay invisible.
        for (int i = 0; i < 4; i++) put(8'h10 + 8'(i), 1'b0);
        status("t1.open", 1'b1, 1'b0, 4'd0, 4'd4);
        put(8'h14, 1'b1);
        status("t1.commit", 1'b0, 1'b0, 4'd5, 4'd5);
        chk("t1.thr", {ft_a, ft_b}, 2'b11);
        for (int i = 0; i < 5; i++) pop("t1.rd", 8'h10 + 8'(i));
        status("t1.drained", 1'b1, 1'b0, 4'd0, 4'd0);

        // Three words then wdrop: rolled back, single drop_event.
        for (int i = 0; i < 3; i++) put(8'hE0 + 8'(i), 1'b0);
        wdrop = 1'b1;
        cyc();
        wdrop = 1'b0;
        n_drop_exp++;
        pulses("t2.drop", 1'b0, 1'b0, 1'b1);
        status("t2.drop", 1'b1, 1'b0, 4'd0, 4'd0);
        cyc();
        pulses("t2.after", 1'b0, 1'b0, 1'b0);
        put(8'hA0, 1'b0);
        put(8'hA1, 1'b1);
        pop("t2.rd0", 8'hA0);
        pop("t2.rd1", 8'hA1);

        // Ten writes into depth 8: two overflows poison the packet, commit becomes drop.
        for (int i = 0; i < 10; i++) begin
            put(8'h30 + 8'(i), 1'b0);
            chk("t3.ovf", {ovf_a, ovf_b}, (i >= 8) ? 2'b11 : 2'b00);
            if (i == 6) status("t3.almost", 1'b1, 1'b0, 4'd0, 4'd7);
            if (i == 7) status("t3.full", 1'b1, 1'b1, 4'd0, 4'd8);
        end
        wcommit = 1'b1;
        cyc();
        wcommit = 1'b0;
        n_drop_exp++;
        pulses("t3.drop", 1'b0, 1'b0, 1'b1);
        status("t3.drop", 1'b1, 1'b0, 4'd0, 4'd0);
        stats("t3");

        // Four packets of 7 across several pointer wraps.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 7; i++) put(8'h40 + 8'(p * 7 + i), i == 6);
            status("t4.pkt", 1'b0, 1'b0, 4'd7, 4'd7);
            for (int i = 0; i < 7; i++) pop("t4.rd", 8'h40 + 8'(p * 7 + i));
        end
        status("t4.end", 1'b1, 1'b0, 4'd0, 4'd0);

        // Read of the last committed word alongside a new commit keeps empty low.
        put(8'h55, 1'b1);
        chk("t5.fwft0", rd_b, 8'h55);
        ren = 1'b1; wen = 1'b1; wdata = 8'h66; wcommit = 1'b1;
        cyc();
        ren = 1'b0; wen = 1'b0; wcommit = 1'b0;
        n_commit_exp++;
        status("t5.overlap", 1'b0, 1'b0, 4'd1, 4'd1);
        chk("t5.reg", rd_a, 8'h55);
        pop("t5.rd", 8'h66);

        // Commit and drop together: drop wins.
        put(8'hC0, 1'b0);
        put(8'hC1, 1'b0);
        wcommit = 1'b1; wdrop = 1'b1;
        cyc();
        wcommit = 1'b0; wdrop = 1'b0;
        n_drop_exp++;
        pulses("t6.drop", 1'b0, 1'b0, 1'b1);
        status("t6.drop", 1'b1, 1'b0, 4'd0, 4'd0);
        ren = 1'b1;
        cyc();
        ren = 1'b0;
        pulses("t6.unf", 1'b0, 1'b1, 1'b0);
        status("t6.unf", 1'b1, 1'b0, 4'd0, 4'd0);
        put(8'h77, 1'b1);
        pulses("t6.unf_off", 1'b0, 1'b0, 1'b0);
        pop("t6.rd", 8'h77);
        stats("t6");

        // Reset mid-packet: 4 committed and 2 open words vanish silently.
        for (int i = 0; i < 4; i++) put(8'h80 + 8'(i), i == 3);
        put(8'h90, 1'b0);
        put(8'h91, 1'b0);
        status("t7.pre", 1'b0, 1'b0, 4'd4, 4'd6);
        rst_n = 1'b0;
        #1;
        status("t7.rst", 1'b1, 1'b0, 4'd0, 4'd0);
        chk("t7.rdata", rd_a, 8'h00);
        n_commit_exp = 0;
        n_drop_exp = 0;
        stats("t7");
        cyc();
        rst_n = 1'b1;
        cyc();
        pulses("t7.after", 1'b0, 1'b0, 1'b0);
        status("t7.after", 1'b1, 1'b0, 4'd0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
